// File: rtl/markov_song_generator.sv
`timescale 1ns/1ps
// markov_song_generator
//   Builds a song of SONG_LEN notes as a Markov chain. The next note is drawn
//   from the candidate pool row selected by the current note, using the low
//   IDX_W bits of an internal Galois LFSR as the slot index. Draws that land
//   outside the populated slots are rejected and redrawn on the next cycle.
//   Notes leave over a valid/ready handshake.
// Ports
//   CLOCK_50      : clock, all logic on the rising edge
//   reset_n       : synchronous active-low reset (also clears the pool)
//   start         : begin a new song, honoured only when idle
//   abort         : cancel a song in progress, wins over a same-cycle accept
//   pool_wr_*     : write one candidate slot; out-of-range slots are dropped
//   note_out      : generated note, note_valid qualifies it
//   note_ready    : consumer accepts note_out
//   note_idx      : position of note_out within the song
//   busy          : song in progress
//   done          : one-cycle pulse after the last note is accepted
module markov_song_generator #(
  parameter int NOTE_W    = 4,
  parameter int POOL_SIZE = 10,
  parameter int IDX_W     = 4,
  parameter int SONG_LEN  = 256,
  parameter int CNT_W     = 9,
  parameter int LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              pool_wr_en,
  input  logic [NOTE_W-1:0] pool_wr_row,
  input  logic [IDX_W-1:0]  pool_wr_slot,
  input  logic [NOTE_W-1:0] pool_wr_data,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_valid,
  input  logic              note_ready,
  output logic [CNT_W-1:0]  note_idx,
  output logic              busy,
  output logic              done
);

  localparam int ROWS = 2 ** NOTE_W;
  localparam logic [IDX_W:0]      POOL_SIZE_C = (IDX_W+1)'(POOL_SIZE);
  localparam logic [CNT_W-1:0]    LAST_IDX    = CNT_W'(SONG_LEN - 1);
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [LFSR_W-1:0]   SEED_C      = (SEED == '0) ? LFSR_W'(1) : SEED;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PICK = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    lfsr_step = (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
  endfunction

  logic [1:0]        state_q,      state_d;
  logic [LFSR_W-1:0] lfsr_q,       lfsr_d;
  logic [NOTE_W-1:0] cur_note_q,   cur_note_d;
  logic [NOTE_W-1:0] note_out_q,   note_out_d;
  logic              note_valid_q, note_valid_d;
  logic [CNT_W-1:0]  note_idx_q,   note_idx_d;

  logic [NOTE_W-1:0] pool_q [ROWS][POOL_SIZE];

  logic [IDX_W-1:0]  draw_r;
  logic              draw_ok;
  logic [NOTE_W-1:0] pool_rd;
  logic              pool_wr_ok;

  assign draw_r     = lfsr_q[IDX_W-1:0];
  assign draw_ok    = {1'b0, draw_r} < POOL_SIZE_C;
  // Only consumed when draw_ok, so out-of-range slots never reach note_out.
  assign pool_rd    = pool_q[cur_note_q][draw_r];
  assign pool_wr_ok = pool_wr_en && ({1'b0, pool_wr_slot} < POOL_SIZE_C);

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    cur_note_d   = cur_note_q;
    note_out_d   = note_out_q;
    note_valid_d = note_valid_q;
    note_idx_d   = note_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_PICK;
          cur_note_d = '0;
          note_idx_d = '0;
        end
      end
      ST_PICK: begin
        // The generator keeps running in every PICK cycle, including rejects.
        lfsr_d = lfsr_step(lfsr_q);
        if (abort) begin
          state_d      = ST_IDLE;
          note_valid_d = 1'b0;
        end else if (draw_ok) begin
          note_out_d   = pool_rd;
          note_valid_d = 1'b1;
          state_d      = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (abort) begin
          state_d      = ST_IDLE;
          note_valid_d = 1'b0;
        end else if (note_valid_q && note_ready) begin
          note_valid_d = 1'b0;
          cur_note_d   = note_out_q;
          if (note_idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            note_idx_d = note_idx_q + 1'b1;
            state_d    = ST_PICK;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      lfsr_q       <= SEED_C;
      cur_note_q   <= '0;
      note_out_q   <= '0;
      note_valid_q <= 1'b0;
      note_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      cur_note_q   <= cur_note_d;
      note_out_q   <= note_out_d;
      note_valid_q <= note_valid_d;
      note_idx_q   <= note_idx_d;
    end
  end

  // A same-cycle PICK reads the old slot contents; the write lands at the edge.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int s = 0; s < POOL_SIZE; s++) begin
          pool_q[r][s] <= '0;
        end
      end
    end else if (pool_wr_ok) begin
      pool_q[pool_wr_row][pool_wr_slot] <= pool_wr_data;
    end
  end

  assign note_out   = note_out_q;
  assign note_valid = note_valid_q;
  assign note_idx   = note_idx_q;
  assign busy       = (state_q == ST_PICK) || (state_q == ST_EMIT);
  assign done       = (state_q == ST_DONE);

endmodule
